// File: rtl/regfile_mp_pkg.sv
// Shared size defaults for the multi-ported register file and its scoreboard.
// Every regfile_mp file imports this package; none of them hard-codes a width.
package regfile_mp_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int ASIZE_DEF = 4;
    localparam int NREG_DEF  = 16;
    localparam int NRD_DEF   = 2;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: the two write ports, packed read ports, reservation and flush.
// The master drives the requests. The slave (the register file) drives read data and busy state.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF
);
    logic                   wen0;
    logic                   wen1;
    logic [ASIZE-1:0]       waddr0;
    logic [ASIZE-1:0]       waddr1;
    logic [DSIZE-1:0]       wdata0;
    logic [DSIZE-1:0]       wdata1;
    logic [NRD*ASIZE-1:0]   raddr;
    logic [NRD*DSIZE-1:0]   rdata;
    logic [NRD-1:0]         rbusy;
    logic                   rsv_en;
    logic [ASIZE-1:0]       rsv_addr;
    logic                   flush;
    logic [NREG-1:0]        busy_vec;

    modport master (
        output wen0, wen1, waddr0, waddr1, wdata0, wdata1, raddr, rsv_en, rsv_addr, flush,
        input  rdata, rbusy, busy_vec
    );

    modport slave (
        input  wen0, wen1, waddr0, waddr1, wdata0, wdata1, raddr, rsv_en, rsv_addr, flush,
        output rdata, rbusy, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Tracks which registers have a reserved but not yet completed write.
// Register 0 is never marked busy.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEF,
    parameter int NREG  = NREG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rsv_en,
    input  logic [ASIZE-1:0] rsv_addr,
    input  logic             wen0,
    input  logic [ASIZE-1:0] waddr0,
    input  logic             wen1,
    input  logic [ASIZE-1:0] waddr1,
    input  logic             flush,
    output logic [NREG-1:0]  busy_vec
);
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clears are applied first, so a new reservation on the same edge overrides them.
    always_comb begin
        busy_nxt = busy;
        if (flush)  busy_nxt = '0;
        if (wen0)   busy_nxt[waddr0] = 1'b0;
        if (wen1)   busy_nxt[waddr1] = 1'b0;
        if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

    assign busy_vec = busy;
endmodule

// File: rtl/regfile_mp.sv
// Register file with two write ports and NRD combinational read ports.
// Reads bypass same-cycle writes, and a pending-write scoreboard drives the per-port busy flags.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int NRD   = NRD_DEF
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    logic [DSIZE-1:0] mem [NREG];
    logic [NREG-1:0]  busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREG; i++) mem[i] <= '0;
        end else begin
            if (bus.wen0 && bus.waddr0 != '0) mem[bus.waddr0] <= bus.wdata0;
            if (bus.wen1 && bus.waddr1 != '0) mem[bus.waddr1] <= bus.wdata1;
        end
    end

    regfile_scoreboard #(
        .ASIZE (ASIZE),
        .NREG  (NREG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .wen0     (bus.wen0),
        .waddr0   (bus.waddr0),
        .wen1     (bus.wen1),
        .waddr1   (bus.waddr1),
        .flush    (bus.flush),
        .busy_vec (busy)
    );

    assign bus.busy_vec = busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ASIZE-1:0] ra;
        logic [DSIZE-1:0] rd;
        logic             hit;

        assign ra = bus.raddr[k*ASIZE +: ASIZE];

        // Port 1 is checked last so that it wins over port 0. Address 0 and reset force zero.
        always_comb begin
            rd  = mem[ra];
            hit = 1'b0;
            if (bus.wen0 && bus.waddr0 == ra) begin
                rd  = bus.wdata0;
                hit = 1'b1;
            end
            if (bus.wen1 && bus.waddr1 == ra) begin
                rd  = bus.wdata1;
                hit = 1'b1;
            end
            if (ra == '0 || !rst) rd = '0;
        end

        assign bus.rdata[k*DSIZE +: DSIZE] = rd;
        assign bus.rbusy[k] = rst && (ra != '0) && busy[ra] && !hit;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a table of single-cycle vectors, then async-reset sequences.
// Instance A uses the default sizes. Instance B uses NRD=4 and DSIZE=32.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic rsta;
    logic rstb;
    always #5 clk = ~clk;

    regfile_mp_if ifa ();
    regfile_mp_if #(.DSIZE(32), .ASIZE(4), .NREG(16), .NRD(4)) ifb ();

    regfile_mp ua (.clk(clk), .rst(rsta), .bus(ifa));
    regfile_mp #(.DSIZE(32), .ASIZE(4), .NREG(16), .NRD(4)) ub (.clk(clk), .rst(rstb), .bus(ifb));

    typedef struct {
        string       name;
        bit          b;
        int          sig;
        int          idx;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic        w0;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        w1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        rsv;
        logic [3:0]  ra;
        logic        fl;
        logic [3:0]  r0;
        logic [3:0]  r1;
        logic [15:0] e0;
        logic [15:0] e1;
        logic        b0;
        logic        b1;
        logic [15:0] ebusy;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] actual(exp_t e);
        case (e.sig)
            0:       return e.b ? ifb.rdata[e.idx*32 +: 32] : {16'h0, ifa.rdata[e.idx*16 +: 16]};
            1:       return e.b ? {31'h0, ifb.rbusy[e.idx]} : {31'h0, ifa.rbusy[e.idx]};
            default: return e.b ? {16'h0, ifb.busy_vec} : {16'h0, ifa.busy_vec};
        endcase
    endfunction

    task automatic push(input string n, input bit b, input int s, input int i, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.b    = b;
        e.sig  = s;
        e.idx  = i;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual(e);
            checks++;
            if (a !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, a, e.val);
            end
        end
    endtask

    task automatic idle_a();
        ifa.wen0 = 0; ifa.wen1 = 0; ifa.waddr0 = 0; ifa.waddr1 = 0;
        ifa.wdata0 = 0; ifa.wdata1 = 0; ifa.rsv_en = 0; ifa.rsv_addr = 0; ifa.flush = 0;
    endtask

    task automatic idle_b();
        ifb.wen0 = 0; ifb.wen1 = 0; ifb.waddr0 = 0; ifb.waddr1 = 0;
        ifb.wdata0 = 0; ifb.wdata1 = 0; ifb.rsv_en = 0; ifb.rsv_addr = 0; ifb.flush = 0;
        ifb.raddr = 0;
    endtask

    vec_t vt[14];

    initial begin
        vt[0]  = '{1, 5, 16'h1234, 0, 0, 16'h0,    0, 0, 0, 5, 0, 16'h1234, 16'h0,    0, 0, 16'h0000};
        vt[1]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 5, 3, 16'h1234, 16'h0,    0, 0, 16'h0000};
        vt[2]  = '{1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0, 0, 5, 3, 16'h1234, 16'h5555, 0, 0, 16'h0000};
        vt[3]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 3, 3, 16'h5555, 16'h5555, 0, 0, 16'h0000};
        vt[4]  = '{1, 0, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0, 0, 0, 0, 16'h0,    16'h0,    0, 0, 16'h0000};
        vt[5]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 0, 7, 0, 16'h0,    16'h0,    0, 0, 16'h0080};
        vt[6]  = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 7, 5, 16'h0,    16'h1234, 1, 0, 16'h0080};
        vt[7]  = '{0, 0, 16'h0,    1, 7, 16'h0042, 0, 0, 0, 7, 7, 16'h0042, 16'h0042, 0, 0, 16'h0000};
        vt[8]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 4, 0, 4, 9, 16'h0,    16'h0,    0, 0, 16'h0010};
        vt[9]  = '{0, 0, 16'h0,    0, 0, 16'h0,    1, 9, 0, 4, 9, 16'h0,    16'h0,    1, 0, 16'h0210};
        vt[10] = '{1, 2, 16'hBEEF, 0, 0, 16'h0,    1, 9, 1, 9, 2, 16'h0,    16'hBEEF, 1, 0, 16'h0200};
        vt[11] = '{1, 6, 16'h0066, 0, 0, 16'h0,    1, 6, 0, 6, 9, 16'h0066, 16'h0,    0, 1, 16'h0240};
        vt[12] = '{1, 9, 16'h0099, 1, 1, 16'h0011, 0, 0, 0, 9, 1, 16'h0099, 16'h0011, 0, 0, 16'h0040};
        vt[13] = '{0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 6, 2, 16'h0066, 16'hBEEF, 1, 0, 16'h0040};

        rsta = 0;
        rstb = 0;
        idle_a();
        idle_b();
        // Writes, reservations and flush are driven during reset; none of them may take effect.
        ifa.wen0 = 1; ifa.waddr0 = 5; ifa.wdata0 = 16'hFFFF;
        ifa.rsv_en = 1; ifa.rsv_addr = 5; ifa.raddr = {4'd5, 4'd5};
        #1;
        push("rst_rd0", 0, 0, 0, 0); push("rst_rb0", 0, 1, 0, 0); push("rst_busy", 0, 2, 0, 0);
        drain();
        repeat (2) @(posedge clk);
        #2;
        idle_a();
        rsta = 1;
        rstb = 1;
        @(posedge clk); #1;
        push("post_rst_rd0", 0, 0, 0, 0); push("post_rst_busy", 0, 2, 0, 0);
        drain();

        for (int i = 0; i < 14; i++) begin
            ifa.wen0 = vt[i].w0; ifa.waddr0 = vt[i].a0; ifa.wdata0 = vt[i].d0;
            ifa.wen1 = vt[i].w1; ifa.waddr1 = vt[i].a1; ifa.wdata1 = vt[i].d1;
            ifa.rsv_en = vt[i].rsv; ifa.rsv_addr = vt[i].ra; ifa.flush = vt[i].fl;
            ifa.raddr = {vt[i].r1, vt[i].r0};
            push($sformatf("v%0d_rd0", i), 0, 0, 0, {16'h0, vt[i].e0});
            push($sformatf("v%0d_rd1", i), 0, 0, 1, {16'h0, vt[i].e1});
            push($sformatf("v%0d_rb0", i), 0, 1, 0, {31'h0, vt[i].b0});
            push($sformatf("v%0d_rb1", i), 0, 1, 1, {31'h0, vt[i].b1});
            #3 drain();
            @(posedge clk); #1;
            push($sformatf("v%0d_busy", i), 0, 2, 0, {16'h0, vt[i].ebusy});
            drain();
        end

        // Reserve and write r8 together, then pull reset low mid-cycle.
        ifa.wen0 = 1; ifa.waddr0 = 8; ifa.wdata0 = 16'h0010;
        ifa.rsv_en = 1; ifa.rsv_addr = 8; ifa.raddr = {4'd3, 4'd8};
        @(posedge clk); #1;
        idle_a();
        push("r8_rd0", 0, 0, 0, 32'h0010); push("r8_rb0", 0, 1, 0, 1); push("r8_busy", 0, 2, 0, 32'h0140);
        #1 drain();
        #1 rsta = 0;
        ifa.wen0 = 1; ifa.waddr0 = 8; ifa.wdata0 = 16'h1111;
        #1;
        push("arst_rd0", 0, 0, 0, 0); push("arst_rb0", 0, 1, 0, 0); push("arst_busy", 0, 2, 0, 0);
        drain();
        @(posedge clk); #2 rsta = 1;
        #1;
        push("rel_bypass_rd0", 0, 0, 0, 32'h1111); push("rel_busy", 0, 2, 0, 0);
        drain();
        @(posedge clk); #1;
        idle_a();
        #1;
        push("rel_write_rd0", 0, 0, 0, 32'h1111); push("rel_r3_rd1", 0, 0, 1, 0);
        drain();

        // Wider instance: four read ports, 32-bit data.
        ifb.wen0 = 1; ifb.waddr0 = 8; ifb.wdata0 = 32'hCAFE_0010;
        ifb.rsv_en = 1; ifb.rsv_addr = 8; ifb.raddr = {4'd8, 4'd8, 4'd8, 4'd8};
        @(posedge clk); #1;
        ifb.wen0 = 0; ifb.rsv_en = 0;
        push("b_rd3", 1, 0, 3, 32'hCAFE_0010); push("b_rb3", 1, 1, 3, 1); push("b_busy", 1, 2, 0, 32'h0100);
        #1 drain();
        #1 rstb = 0;
        #1;
        for (int k = 0; k < 4; k++) begin
            push($sformatf("b_arst_rd%0d", k), 1, 0, k, 0);
            push($sformatf("b_arst_rb%0d", k), 1, 1, k, 0);
        end
        push("b_arst_busy", 1, 2, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DSIZE, default 16, data width in bits.
REQ-002 Parameter ASIZE, default 4, register address width.
REQ-003 Parameter NREG, default 16, register count; SHALL equal 2**ASIZE.
REQ-004 Parameter NRD, default 2, number of read ports (1..4).
REQ-005 Port clk  input  1  single clock, all state updates on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-low.
REQ-007 Port wen0, wen1  input  1 each  write enables, ports 0 and 1.
REQ-008 Port waddr0, waddr1  input  ASIZE each  write addresses.
REQ-009 Port wdata0, wdata1  input  DSIZE each  write data.
REQ-010 Port raddr  input  NRD*ASIZE  packed read addresses; port k at bits [k*ASIZE +: ASIZE].
REQ-011 Port rdata  output  NRD*DSIZE  packed read data; port k at bits [k*DSIZE +: DSIZE].
REQ-012 Port rbusy  output  NRD  per-read-port pending-write flag.
REQ-013 Port rsv_en  input  1  reserve destination register (issue of a producer).
REQ-014 Port rsv_addr  input  ASIZE  register to mark busy.
REQ-015 Port flush  input  1  clear all busy bits.
REQ-016 Port busy_vec  output  NREG  scoreboard state, bit i = register i busy.

Function
REQ-017 Register 0 SHALL read 0 always; writes and reservations to address 0 SHALL be ignored.
REQ-018 On a rising edge, each register with an enabled write SHALL load that port's data.
REQ-019 Both write ports enabled to the same nonzero address: port 1 SHALL win.
REQ-020 Read ports SHALL be combinational (zero latency) with same-cycle bypass: rdata_k = wdata1 if wen1 and waddr1==raddr_k, else wdata0 if wen0 and waddr0==raddr_k, else array value; raddr_k==0 SHALL return 0 regardless of bypass.
REQ-021 Scoreboard: busy[i] SHALL be set on the edge where rsv_en and rsv_addr==i (i≠0).
REQ-022 busy[i] SHALL clear on the edge where wen0 or wen1 writes register i.
REQ-023 Set and clear of the same register in one cycle: set SHALL win (newer producer pending).
REQ-024 flush SHALL clear all busy bits on the edge; a simultaneous rsv_en SHALL still set its bit.
REQ-025 rbusy_k = busy[raddr_k] AND NOT (write to raddr_k this cycle); rbusy_k SHALL be 0 for address 0.
REQ-026 busy_vec SHALL reflect registered busy state only (no same-cycle terms); bit 0 SHALL be 0.
REQ-027 Write with no prior reservation SHALL update data and leave busy bit 0; no error flag.

Reset
REQ-028 rst low SHALL asynchronously clear all registers and all busy bits to 0.
REQ-029 During reset rdata SHALL be 0 for every port, rbusy and busy_vec SHALL be 0; writes, reservations and flush SHALL be ignored.
REQ-030 Reset deassertion mid-operation SHALL resume with all state zero; first write takes effect on the first rising edge with rst high.

Structure
REQ-031 DSIZE, ASIZE, NREG defaults SHALL come from the shared define file; no local hard-coded widths.
REQ-032 The scoreboard SHALL be a separate sub-module regfile_scoreboard (inputs: rsv, write clears, flush; output busy_vec); the data array, bypass and read muxing stay in regfile_mp.
REQ-033 Read ports SHALL be generated by a generate loop over NRD; no per-port duplicated code.

Verification
REQ-034 Reset, then write r5=16'h1234 via port 0, read raddr0=5 next cycle -> rdata0=16'h1234, rbusy0=0.
REQ-035 Same cycle wen0 r3=16'hAAAA and wen1 r3=16'h5555, raddr1=3 -> bypass 16'h5555 that cycle and array r3=16'h5555 after.
REQ-036 Write r0=16'hFFFF on both ports, rsv_addr=0 -> rdata for r0=0, busy_vec[0]=0.
REQ-037 rsv r7, next cycle raddr0=7 -> rbusy0=1; next cycle wen1 r7=16'h0042 -> rbusy0=0, rdata0=16'h0042 same cycle, busy_vec[7]=0 after edge.
REQ-038 busy r4,r9; cycle with flush=1, rsv_en r9, wen0 r2 -> busy_vec after edge = only bit 9 set; rsv r6 and wen0 r6 same cycle -> busy_vec[6]=1.
REQ-039 Assert rst low asynchronously mid-stream with r8=16'h0010 and busy[8]=1 -> immediately rdata for r8=0, busy_vec=0; repeat with NRD=4, DSIZE=32.
